elevator_scan_ctrl: RTL
=======================

ELEVATOR_SCAN_CTRL -- requirements
Module: elevator_scan_ctrl

Interface
REQ-001 Parameter NUM_FLOORS, default 8, number of floors served; legal range 2..16.
REQ-002 Parameter TRAVEL_CYCLES, default 4, clock cycles to travel one floor; legal range >=1.
REQ-003 Parameter DOOR_CYCLES, default 3, minimum clock cycles the door stays open per stop; legal range >=1.
REQ-004 Localparam FW = clog2(NUM_FLOORS), width of the floor index.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 floor_request  input  NUM_FLOORS  one bit per floor; bit f high for one or more cycles requests floor f.
REQ-008 door_hold  input  1  while high in DOOR, reloads the door timer.
REQ-009 current_floor  output  FW  registered floor index.
REQ-010 door_open  output  1  high exactly while the FSM is in DOOR.
REQ-011 direction  output  2  00 idle, 01 up, 10 down; 11 never driven.
REQ-012 pending  output  NUM_FLOORS  registered latched-request vector.

Function
REQ-013 The FSM SHALL have three states: IDLE, MOVE and DOOR.
REQ-014 pending SHALL update each cycle as pending | floor_request, except that the serviced floor's bit is cleared on DOOR entry and is never set while in DOOR at current_floor.
REQ-015 IDLE: if pending[current_floor]=1, the block SHALL enter DOOR on the next edge with direction 00.
REQ-016 IDLE: otherwise, if requests exist only above, go to MOVE up; only below, go to MOVE down; both, go to MOVE in last_dir (internal register, reset to up, updated on every MOVE entry).
REQ-017 MOVE SHALL load a travel counter with TRAVEL_CYCLES-1 and decrement it each cycle; on the edge where it equals 0, current_floor SHALL step by +/-1.
REQ-018 On the arrival edge, if pending at the new floor is 1, the block SHALL enter DOOR at that edge and clear that bit; otherwise it SHALL reload the counter and continue in the same direction.
REQ-019 DOOR SHALL last DOOR_CYCLES cycles; door_hold=1 or floor_request[current_floor]=1 during DOOR SHALL reload the timer to DOOR_CYCLES.
REQ-020 On DOOR expiry, the block SHALL go to MOVE if requests remain in the current direction, reverse and go to MOVE if requests remain only in the opposite direction, and otherwise go to IDLE with direction 00.
REQ-021 direction SHALL hold the travel direction throughout MOVE and across DOOR stops between MOVE segments.
REQ-022 current_floor SHALL never exceed NUM_FLOORS-1 or go below 0; no move SHALL be issued past a boundary floor.
REQ-023 Latency from IDLE at floor c to door_open for a request at f!=c SHALL be 2 + |f-c|*TRAVEL_CYCLES cycles, counted from the cycle the request is asserted.
REQ-024 Requests arriving during MOVE for a floor ahead SHALL be served on the current sweep (SCAN order); requests behind SHALL wait for reversal.

Reset
REQ-025 While reset is high, the block SHALL asynchronously force state=IDLE, current_floor=0, door_open=0, direction=00, pending=0, last_dir=up, and all counters to 0.
REQ-026 Reset asserted mid-MOVE or mid-DOOR SHALL discard all pending requests, with no partial floor step.
REQ-027 After reset deasserts, the first edge SHALL sample floor_request normally.

Verification (NUM_FLOORS=8, TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-028 Pulse reset mid-MOVE -> outputs immediately 0/0/00, pending=0; block stays in IDLE until the next request.
REQ-029 Idle at 0, pulse floor_request=8'h08 -> direction=01 after 2 edges, current_floor steps every 4 cycles, door_open=1 at floor 3 on cycle 14 for 3 cycles, then direction=00.
REQ-030 Moving up from floor 2 toward 6, request floors 1 and 4 -> stops at 4, then 6, then reverses (direction=10) and stops at 1.
REQ-031 Idle at floor 4 with last_dir=up, simultaneous requests 1 and 7 -> serves 7 first, then 1.
REQ-032 In DOOR at floor 5, hold door_hold=1 for 6 cycles -> door_open stays 1 until 3 cycles after door_hold falls; a same-floor request does not set pending[5].
REQ-033 At floor 7, request floor 7 -> door opens next edge, no MOVE, current_floor never exceeds 7.

Source files
------------

// File: rtl/elevator_scan_ctrl.sv
// SCAN elevator controller: sweeps in one direction while requests remain ahead,
// stopping at every requested floor, then reverses or parks.
module elevator_scan_ctrl #(
    parameter int NUM_FLOORS    = 8,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_FLOORS-1:0]         floor_request,
    input  logic                          door_hold,
    output logic [$clog2(NUM_FLOORS)-1:0] current_floor,
    output logic                          door_open,
    output logic [1:0]                    direction,
    output logic [NUM_FLOORS-1:0]         pending
);
    localparam int FW = $clog2(NUM_FLOORS);
    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES - 1);
    localparam logic [FW-1:0] TOP_FLOOR   = FW'(NUM_FLOORS - 1);
    localparam logic [1:0]    DIR_IDLE    = 2'b00;
    localparam logic [1:0]    DIR_UP      = 2'b01;
    localparam logic [1:0]    DIR_DOWN    = 2'b10;

    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

    state_t                state_reg, state_next;
    logic [FW-1:0]         floor_reg, floor_next;
    logic [1:0]            dir_reg, dir_next;
    logic                  last_up_reg, last_up_next;
    logic [NUM_FLOORS-1:0] pending_reg, pending_next;
    logic [TW-1:0]         travel_reg, travel_next;
    logic [DW-1:0]         door_reg, door_next;

    logic [NUM_FLOORS-1:0] above_mask, below_mask;
    logic                  req_above, req_below;
    logic [FW-1:0]         step_floor;
    logic                  can_step;
    logic                  going_up, req_ahead, req_behind;

    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_mask
        assign above_mask[gi] = (FW'(gi) > floor_reg);
        assign below_mask[gi] = (FW'(gi) < floor_reg);
    end

    assign req_above  = |(pending_reg & above_mask);
    assign req_below  = |(pending_reg & below_mask);
    assign step_floor = (dir_reg == DIR_DOWN) ? floor_reg - FW'(1) : floor_reg + FW'(1);
    // Guard against stepping past either end of the shaft.
    assign can_step   = ((dir_reg == DIR_UP) && (floor_reg != TOP_FLOOR)) ||
                        ((dir_reg == DIR_DOWN) && (floor_reg != '0));

    always_comb begin
        state_next   = state_reg;
        floor_next   = floor_reg;
        dir_next     = dir_reg;
        last_up_next = last_up_reg;
        travel_next  = travel_reg;
        door_next    = door_reg;
        pending_next = pending_reg | floor_request;
        // A stop from IDLE has no travel direction; fall back to the last one used.
        going_up     = (dir_reg == DIR_UP) || ((dir_reg == DIR_IDLE) && last_up_reg);
        req_ahead    = going_up ? req_above : req_below;
        req_behind   = going_up ? req_below : req_above;

        case (state_reg)
            IDLE: begin
                if (pending_reg[floor_reg]) begin
                    state_next              = DOOR;
                    dir_next                = DIR_IDLE;
                    door_next               = DOOR_LOAD;
                    pending_next[floor_reg] = 1'b0;
                end else if (req_above || req_below) begin
                    state_next  = MOVE;
                    travel_next = TRAVEL_LOAD;
                    if (req_above && (!req_below || last_up_reg)) begin
                        dir_next     = DIR_UP;
                        last_up_next = 1'b1;
                    end else begin
                        dir_next     = DIR_DOWN;
                        last_up_next = 1'b0;
                    end
                end
            end
            MOVE: begin
                if (travel_reg != '0) begin
                    travel_next = travel_reg - TW'(1);
                end else if (can_step) begin
                    travel_next = TRAVEL_LOAD;
                    floor_next  = step_floor;
                    if (pending_reg[step_floor]) begin
                        state_next               = DOOR;
                        door_next                = DOOR_LOAD;
                        pending_next[step_floor] = 1'b0;
                    end
                end else begin
                    state_next = IDLE;
                    dir_next   = DIR_IDLE;
                end
            end
            DOOR: begin
                pending_next[floor_reg] = 1'b0;
                if (door_hold || floor_request[floor_reg]) begin
                    door_next = DOOR_LOAD;
                end else if (door_reg != '0) begin
                    door_next = door_reg - DW'(1);
                end else if (req_ahead || req_behind) begin
                    state_next   = MOVE;
                    travel_next  = TRAVEL_LOAD;
                    last_up_next = req_ahead ? going_up : !going_up;
                    dir_next     = (req_ahead ? going_up : !going_up) ? DIR_UP : DIR_DOWN;
                end else begin
                    state_next = IDLE;
                    dir_next   = DIR_IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                dir_next   = DIR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            floor_reg   <= '0;
            dir_reg     <= DIR_IDLE;
            last_up_reg <= 1'b1;
            pending_reg <= '0;
            travel_reg  <= '0;
            door_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            floor_reg   <= floor_next;
            dir_reg     <= dir_next;
            last_up_reg <= last_up_next;
            pending_reg <= pending_next;
            travel_reg  <= travel_next;
            door_reg    <= door_next;
        end
    end

    assign current_floor = floor_reg;
    assign door_open     = (state_reg == DOOR);
    assign direction     = dir_reg;
    assign pending       = pending_reg;

endmodule
